// File: rtl/tia_playfield_scheduler_if.sv
// tia_playfield_scheduler_if: CPU-side register write and RSYNC strobes into the playfield scheduler
interface tia_pf_if;
  logic       rsync;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  modport master(output rsync, wr_en, wr_addr, wr_data);
  modport slave(input rsync, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/tia_playfield_scheduler.sv
// tia_playfield_scheduler: TIA horizontal counter and per-pixel playfield bit sequencer.
// Optional TIA_PF_SCORE_EN registers pf_half for score-mode color selection.
module tia_playfield_scheduler #(
  parameter int HBLANK_END = 68,
  parameter int LINE_LEN   = 228
) (
  input  logic       clk,
  input  logic       reset_n,
  tia_pf_if.slave    bus,
  output logic [7:0] hcount,
  output logic       hblank,
  output logic       pf_out,
  output logic       pf_half
);
  localparam logic [7:0] HB = 8'(HBLANK_END);
  localparam logic [7:0] HR = 8'(HBLANK_END + 80);
  localparam logic [7:0] HL = 8'(LINE_LEN - 1);
  typedef enum logic [1:0] {HBLANK, LEFT, RIGHT} phase_t;
  phase_t      phase;
  logic [7:0]  h, off, pf1, pf2, pf1_r;
  logic [3:0]  pf0;
  logic [5:0]  p;
  logic [4:0]  b;
  logic [19:0] pf_bits;
  logic        ref_bit, score, boundary, sel;
  // pf_bits is the 20-bit half-line in display order: PF0 D4..D7, PF1 D7..D0, PF2 D0..D7
  always_comb begin
    phase    = h < HB ? HBLANK : h < HR ? LEFT : RIGHT;
    off      = h - HB;
    p        = off[7:2];
    boundary = off[1:0] == 2'd0;
    b        = 5'(phase == LEFT ? p : ref_bit ? 6'd39 - p : p - 6'd20);
    pf1_r    = {<<{pf1}};
    pf_bits  = {pf2, pf1_r, pf0};
    sel      = pf_bits[b];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      h       <= '0;
      pf0     <= '0;
      pf1     <= '0;
      pf2     <= '0;
      ref_bit <= 1'b0;
      score   <= 1'b0;
      pf_out  <= 1'b0;
    end else begin
      h      <= bus.rsync || h == HL ? 8'd0 : h + 8'd1;
      pf_out <= phase == HBLANK ? 1'b0 : boundary ? sel : pf_out;
      if (bus.wr_en && bus.wr_addr == 2'd0) pf0 <= bus.wr_data[7:4];
      if (bus.wr_en && bus.wr_addr == 2'd1) pf1 <= bus.wr_data;
      if (bus.wr_en && bus.wr_addr == 2'd2) pf2 <= bus.wr_data;
      if (bus.wr_en && bus.wr_addr == 2'd3) {score, ref_bit} <= bus.wr_data[1:0];
    end
`ifdef TIA_PF_SCORE_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pf_half <= 1'b0;
    else pf_half <= phase == HBLANK ? 1'b0 : boundary ? phase == RIGHT && score : pf_half;
`else
  logic unused_score;
  assign unused_score = score;
  assign pf_half = 1'b0;
`endif
  assign hcount = h;
  assign hblank = phase == HBLANK;
endmodule

// File: tb/tb_tia_playfield_scheduler.sv
// tb_tia_playfield_scheduler: directed and random stimulus against a line-level playfield model.
module tb_tia_playfield_scheduler;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] hcount;
  logic       hblank, pf_out, pf_half;
  int         checks = 0, failures = 0;
  int         m_h = 0;
  logic [7:0] m_pf0 = 0, m_pf1 = 0, m_pf2 = 0;
  logic       m_ref = 0, m_score = 0, m_pf = 0, m_half = 0;
  tia_pf_if bus();
  tia_playfield_scheduler dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .hcount(hcount), .hblank(hblank), .pf_out(pf_out), .pf_half(pf_half)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h h=%0d", tag, got, exp, m_h);
    end
  endtask
  function automatic logic model_bit(int pix);
    int bi;
    bi = pix < 20 ? pix : m_ref ? 39 - pix : pix - 20;
    if (bi < 4) return m_pf0[4 + bi];
    if (bi < 12) return m_pf1[11 - bi];
    return m_pf2[bi - 12];
  endfunction
  task automatic model_reset();
    m_h = 0; m_pf0 = 0; m_pf1 = 0; m_pf2 = 0;
    m_ref = 0; m_score = 0; m_pf = 0; m_half = 0;
  endtask
  task automatic check_all();
    chk("hcount", hcount, m_h);
    chk("hblank", hblank, m_h < 68);
    chk("pf_out", pf_out, m_pf);
`ifdef TIA_PF_SCORE_EN
    chk("pf_half", pf_half, m_half);
`else
    chk("pf_half", pf_half, 0);
`endif
  endtask
  task automatic step(input logic rs, input logic we, input logic [1:0] a, input logic [7:0] d);
    bus.rsync = rs; bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk);
    if (m_h < 68) begin
      m_pf = 0; m_half = 0;
    end else if ((m_h - 68) % 4 == 0) begin
      m_pf = model_bit((m_h - 68) / 4);
      m_half = m_h >= 148 && m_score;
    end
    if (we && a == 0) m_pf0 = d & 8'hF0;
    if (we && a == 1) m_pf1 = d;
    if (we && a == 2) m_pf2 = d;
    if (we && a == 3) begin m_ref = d[0]; m_score = d[1]; end
    m_h = rs ? 0 : (m_h + 1) % 228;
    #1;
    check_all();
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(0, 1, a, d);
  endtask
  initial begin
    int ones, first, last, lft, rgt;
    bus.rsync = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    #12;
    check_all();
    reset_n = 1;
    idle(227);
    chk("count_227", hcount, 227);
    idle(1);
    chk("wrap_0", hcount, 0);
    // left half copy and right copy of PF0 D4
    wr(0, 8'h10); wr(1, 0); wr(2, 0); wr(3, 0);
    step(1, 0, 0, 0);
    ones = 0; first = -1;
    repeat (228) begin
      idle(1);
      if (pf_out === 1'b1) begin ones++; if (first < 0) first = int'(hcount); end
    end
    chk("left_ones", ones, 8);
    chk("left_first", first, 69);
    // reflect: b=19 at both sides of the centre
    wr(0, 0); wr(2, 8'h80); wr(3, 8'h01);
    step(1, 0, 0, 0);
    ones = 0; first = -1; last = -1;
    repeat (228) begin
      idle(1);
      if (pf_out === 1'b1) begin ones++; last = int'(hcount); if (first < 0) first = int'(hcount); end
    end
    chk("ref_ones", ones, 8);
    chk("ref_first", first, 145);
    chk("ref_last", last, 152);
    // mid-pixel write of PF1 D7 inside pixel 4
    wr(2, 0); wr(3, 0); wr(1, 0);
    step(1, 0, 0, 0);
    while (m_h != 85) idle(1);
    wr(1, 8'h80);
    lft = 0; rgt = 0;
    do begin
      idle(1);
      if (pf_out === 1'b1) begin if (m_h <= 148) lft++; else rgt++; end
    end while (m_h != 0);
    chk("midwr_left", lft, 0);
    chk("midwr_right", rgt, 4);
    // rsync in the visible region
    wr(1, 8'hFF); wr(2, 8'hFF);
    while (m_h != 120) idle(1);
    chk("pre_rsync_pf", pf_out, 1);
    step(1, 0, 0, 0);
    chk("rsync_h", hcount, 0);
    chk("rsync_hblank", hblank, 1);
    idle(1);
    chk("rsync_pf", pf_out, 0);
    // asynchronous reset mid-line
    while (m_h != 100) idle(1);
    chk("pre_reset_pf", pf_out, 1);
    #2 reset_n = 0;
    #1;
    model_reset();
    chk("arst_h", hcount, 0);
    chk("arst_hblank", hblank, 1);
    chk("arst_pf", pf_out, 0);
    #2 reset_n = 1;
    idle(100);
`ifdef TIA_PF_SCORE_EN
    wr(3, 8'h02); wr(2, 8'hFF);
    step(1, 0, 0, 0);
    idle(1);
    ones = 0;
    repeat (228) begin
      idle(1);
      if (pf_half === 1'b1) ones++;
    end
    chk("score_half_cnt", ones, 80);
`endif
    repeat (2000)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
           2'($urandom_range(0, 3)), 8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
